rs_chien_eval: RTL and testbench
================================

Name: rs_chien_eval

Overview:
Consumer end of the Chien search root stream. It latches the error-locator polynomial sigma(x) from the Berlekamp-Massey stage. It then evaluates sigma at ROOTS_PER_CYCLE__CHIEN field elements per cycle, as supplied by the root generator over CYCLES_NUM__CHIEN cycles. It collects the error positions and flags decode failure when the number of roots found differs from the sigma degree. Its outputs feed the Forney/correction stage.

Parameters:
None local. All sizing comes from gf_pkg:
- SYMB_WIDTH: symbol width m; field GF(2^m)
- T_LEN: correction capability t; sigma has T_LEN+1 coefficients
- ROOTS_PER_CYCLE__CHIEN: lanes evaluated per cycle
- CYCLES_NUM__CHIEN: beats per search, equal to ceil((2^m-1)/ROOTS_PER_CYCLE__CHIEN)
- CNT_W: $clog2(T_LEN+1)

Ports:
- aclk  in  1  clock
- aresetn  in  1  synchronous active-low reset
- sigma_vld  in  1  start pulse; sigma and sigma_deg are valid this cycle
- sigma  in  SYMB_WIDTH x [T_LEN:0]  sigma coefficients, index = power of x, sigma[0]=1
- sigma_deg  in  CNT_W  degree of sigma
- roots_vld  in  1  root beat valid
- roots  in  SYMB_WIDTH x [ROOTS_PER_CYCLE__CHIEN-1:0]  alpha^k per lane
- alpha_current  in  SYMB_WIDTH x [ROOTS_PER_CYCLE__CHIEN-1:0]  exponent k per lane
- busy  out  1  search in progress; sigma_vld is ignored while high
- err_pos_vld  out  1  one-cycle result pulse
- err_pos  out  SYMB_WIDTH x [T_LEN-1:0]  error positions, in discovery order
- err_num  out  CNT_W  number of roots found, saturating at T_LEN
- decode_fail  out  1  valid while err_pos_vld is high

Behaviour:
- Clock aclk; reset aresetn is synchronous and active-low. Every register updates only on the posedge of aclk.
- Reset: state IDLE. busy, err_pos_vld, err_pos, err_num, decode_fail, the beat counter, the overflow flag and the latched sigma all clear to 0.
- FSM states: IDLE, SEARCH, (DRAIN when the optional feature is enabled), DONE.
- IDLE -> SEARCH on sigma_vld:
  - latch sigma and sigma_deg
  - clear err_pos, err_num, overflow and the beat counter
- In IDLE and DONE, roots_vld is ignored.
- SEARCH, on each roots_vld beat:
  - For lane i, compute e_i = sigma(roots[i]) by Horner's method with gf_mult.
  - Lane i is valid iff alpha_current[i] < 2^m-1. This masks the padding lanes of the final beat.
  - A hit is a valid lane with e_i == 0.
  - Each hit writes err_pos[err_num + rank], where rank = number of hits in lower lanes this beat.
  - Position = (2^m-1 - alpha_current[i]) mod (2^m-1), so k=0 maps to position 0.
  - err_num += hits, saturating at T_LEN. Hits that would exceed T_LEN set overflow and are dropped.
  - The beat counter increments.
- Cycles in SEARCH without roots_vld are stalls: no state change, no timeout.
- SEARCH -> DONE on the edge that accepts beat CYCLES_NUM__CHIEN-1, including that beat's hits.
- DONE lasts one cycle:
  - err_pos_vld = 1
  - decode_fail = overflow | (err_num != sigma_deg)
  - then DONE -> IDLE
- Outputs hold their values after DONE until the next sigma_vld.
- busy = (state != IDLE).
- A sigma_vld arriving in the DONE cycle is ignored; the source waits for busy low.
- Latency: err_pos_vld rises exactly 1 cycle after the last root beat.
- Entries of err_pos at index >= err_num are 0.
- Reset mid-search aborts to IDLE with all reset values. The next sigma_vld then runs cleanly.
- All field arithmetic is XOR/gf_mult in GF(2^m). Counters use plain binary widths as above.

Optional Feature:
- Macro: RS_CHIEN_EVAL_PIPE_EN.
- Defined:
  - one register stage after the per-lane evaluation, holding the hit mask and alpha_current
  - the last beat moves SEARCH -> DRAIN -> DONE, so err_pos_vld comes 2 cycles after the last beat
  - reset clears the pipeline register
- Undefined: evaluation and accumulation happen in the same cycle; latency is 1.

Decomposition:
- gf_pkg supplies SYMB_WIDTH, T_LEN, ROOTS_PER_CYCLE__CHIEN, CYCLES_NUM__CHIEN, gf_mult and alpha_to_symb.
- Add to gf_pkg:
  - CNT_W
  - GF_ORDER = 2^SYMB_WIDTH-1
  - an FSM state enum typedef
- Sub-module rs_poly_eval: combinational Horner evaluation of one lane. It takes sigma and x and returns the SYMB_WIDTH result, and is instantiated ROOTS_PER_CYCLE__CHIEN times.

Test Plan:
Common configuration: m=8, T_LEN=8, ROOTS_PER_CYCLE__CHIEN=4, CYCLES_NUM__CHIEN=64.
1. sigma=1, sigma_deg=0, then 64 beats -> err_pos_vld 1 cycle after beat 63; err_num=0; decode_fail=0; err_pos all 0.
2. sigma=1+alpha^3·x, sigma_deg=1 -> hit at k=252, lane 0 of beat 63 -> err_pos[0]=3, err_num=1, decode_fail=0. Lane k=255 is masked and produces no spurious hit.
3. sigma=(1+x)(1+alpha^254·x), sigma_deg=2 -> err_pos[0]=0, err_pos[1]=254, err_num=2, decode_fail=0; both hits land in the same beat (beat 0, lanes 0 and 1).
4. sigma=1+alpha^3·x with sigma_deg=2 -> err_num=1, decode_fail=1.
5. Insert roots_vld gaps of 3 cycles every 5 beats -> results identical to test 3; busy stays high through the gaps. A second sigma_vld during SEARCH is ignored.
6. aresetn low for 1 cycle during beat 20 -> next cycle: busy=0 and all outputs 0; no err_pos_vld. A fresh run of test 2 then passes.

Source files
------------

// File: rtl/gf_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : gf_pkg
//  Purpose  : GF(2^m) sizing, arithmetic helpers and Chien-evaluator FSM states.
//  Revision : 1.0  initial release
// ============================================================================
package gf_pkg;

  localparam int SYMB_WIDTH             = 8;
  localparam int T_LEN                  = 8;
  localparam int ROOTS_PER_CYCLE__CHIEN = 4;
  localparam int GF_ORDER               = (1 << SYMB_WIDTH) - 1;
  localparam int CYCLES_NUM__CHIEN      =
    (GF_ORDER + ROOTS_PER_CYCLE__CHIEN - 1) / ROOTS_PER_CYCLE__CHIEN;
  localparam int CNT_W                  = $clog2(T_LEN + 1);
  localparam int BEAT_W                 =
    (CYCLES_NUM__CHIEN > 1) ? $clog2(CYCLES_NUM__CHIEN) : 1;

  // Primitive polynomial x^8 + x^4 + x^3 + x^2 + 1
  localparam logic [SYMB_WIDTH:0] PRIM_POLY = 9'h11D;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_DONE   = 2'd3
  } chien_state_t;

  function automatic logic [SYMB_WIDTH-1:0] gf_mult(
    input logic [SYMB_WIDTH-1:0] a,
    input logic [SYMB_WIDTH-1:0] b
  );
    logic [SYMB_WIDTH-1:0] acc;
    logic [SYMB_WIDTH-1:0] sh;
    acc = '0;
    sh  = a;
    for (int i = 0; i < SYMB_WIDTH; i++) begin
      if (b[i]) acc = acc ^ sh;
      sh = sh[SYMB_WIDTH-1] ? ((sh << 1) ^ PRIM_POLY[SYMB_WIDTH-1:0]) : (sh << 1);
    end
    return acc;
  endfunction

  function automatic logic [SYMB_WIDTH-1:0] alpha_to_symb(
    input logic [SYMB_WIDTH-1:0] k
  );
    logic [SYMB_WIDTH-1:0] r;
    r = SYMB_WIDTH'(1);
    for (int i = 0; i < GF_ORDER; i++) begin
      if (i < int'(k)) r = gf_mult(r, SYMB_WIDTH'(2));
    end
    return r;
  endfunction

  // Root at alpha^k corresponds to error position (-k) mod GF_ORDER
  function automatic logic [SYMB_WIDTH-1:0] gf_pos(
    input logic [SYMB_WIDTH-1:0] k
  );
    return (k == '0) ? '0 : (SYMB_WIDTH'(GF_ORDER) - k);
  endfunction

endpackage
`default_nettype wire

// File: rtl/rs_poly_eval.sv
`default_nettype none
// ============================================================================
//  Module   : rs_poly_eval
//  Purpose  : Combinational Horner evaluation of sigma(x) for one lane.
//  Revision : 1.0  initial release
// ============================================================================
module rs_poly_eval
  import gf_pkg::*;
(
  input  logic [T_LEN:0][SYMB_WIDTH-1:0] sigma,
  input  logic [SYMB_WIDTH-1:0]          x,
  output logic [SYMB_WIDTH-1:0]          y
);

  logic [SYMB_WIDTH-1:0] w_acc;

  always_comb begin
    w_acc = sigma[T_LEN];
    for (int i = T_LEN - 1; i >= 0; i--) begin
      w_acc = gf_mult(w_acc, x) ^ sigma[i];
    end
  end

  assign y = w_acc;

endmodule
`default_nettype wire

// File: rtl/rs_chien_eval.sv
`default_nettype none
// ============================================================================
//  Module   : rs_chien_eval
//  Purpose  : Chien search consumer: evaluates sigma on the root stream, collects
//             error positions and flags decode failure.
//             Optional macro RS_CHIEN_EVAL_PIPE_EN adds a hit-mask pipeline stage.
//  Revision : 1.0  initial release
// ============================================================================
module rs_chien_eval
  import gf_pkg::*;
(
  input  logic                                                aclk,
  input  logic                                                aresetn,
  input  logic                                                sigma_vld,
  input  logic [T_LEN:0][SYMB_WIDTH-1:0]                      sigma,
  input  logic [CNT_W-1:0]                                    sigma_deg,
  input  logic                                                roots_vld,
  input  logic [ROOTS_PER_CYCLE__CHIEN-1:0][SYMB_WIDTH-1:0]   roots,
  input  logic [ROOTS_PER_CYCLE__CHIEN-1:0][SYMB_WIDTH-1:0]   alpha_current,
  output logic                                                busy,
  output logic                                                err_pos_vld,
  output logic [T_LEN-1:0][SYMB_WIDTH-1:0]                    err_pos,
  output logic [CNT_W-1:0]                                    err_num,
  output logic                                                decode_fail
);

  localparam int LANES = ROOTS_PER_CYCLE__CHIEN;

  chien_state_t                           r_state;
  chien_state_t                           w_state_nxt;
  logic [T_LEN:0][SYMB_WIDTH-1:0]         r_sigma;
  logic [CNT_W-1:0]                       r_sigma_deg;
  logic [BEAT_W-1:0]                      r_beat_cnt;
  logic                                   r_overflow;
  logic [T_LEN-1:0][SYMB_WIDTH-1:0]       r_err_pos;
  logic [CNT_W-1:0]                       r_err_num;
  logic                                   r_fail_hold;

  logic [LANES-1:0][SYMB_WIDTH-1:0]       w_eval;
  logic [LANES-1:0]                       w_hit;
  logic                                   w_beat_acc;
  logic                                   w_last_beat;
  logic                                   w_start;
  logic                                   w_fail;

  logic                                   w_acc_vld;
  logic [LANES-1:0]                       w_acc_hit;
  logic [LANES-1:0][SYMB_WIDTH-1:0]       w_acc_k;
  logic [T_LEN-1:0][SYMB_WIDTH-1:0]       w_err_pos_nxt;
  logic [CNT_W-1:0]                       w_err_num_nxt;
  logic                                   w_ovf_nxt;

  assign w_start     = (r_state == ST_IDLE) && sigma_vld;
  assign w_beat_acc  = (r_state == ST_SEARCH) && roots_vld;
  assign w_last_beat = w_beat_acc && (r_beat_cnt == BEAT_W'(CYCLES_NUM__CHIEN - 1));
  assign w_fail      = r_overflow | (r_err_num != r_sigma_deg);

  // Lanes with k >= GF_ORDER are padding on the final beat
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    rs_poly_eval u_eval (
      .sigma (r_sigma),
      .x     (roots[i]),
      .y     (w_eval[i])
    );
    assign w_hit[i] = (alpha_current[i] < SYMB_WIDTH'(GF_ORDER)) && (w_eval[i] == '0);
  end

`ifdef RS_CHIEN_EVAL_PIPE_EN
  logic                             r_pipe_vld;
  logic [LANES-1:0]                 r_pipe_hit;
  logic [LANES-1:0][SYMB_WIDTH-1:0] r_pipe_k;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_pipe_vld <= 1'b0;
      r_pipe_hit <= '0;
      r_pipe_k   <= '0;
    end else begin
      r_pipe_vld <= w_beat_acc;
      r_pipe_hit <= w_hit;
      r_pipe_k   <= alpha_current;
    end
  end

  assign w_acc_vld = r_pipe_vld;
  assign w_acc_hit = r_pipe_hit;
  assign w_acc_k   = r_pipe_k;
`else
  assign w_acc_vld = w_beat_acc;
  assign w_acc_hit = w_hit;
  assign w_acc_k   = alpha_current;
`endif

  // Hits are packed in lane order after the entries already collected
  always_comb begin
    w_err_pos_nxt = r_err_pos;
    w_err_num_nxt = r_err_num;
    w_ovf_nxt     = r_overflow;
    if (w_acc_vld) begin
      for (int i = 0; i < LANES; i++) begin
        if (w_acc_hit[i]) begin
          if (w_err_num_nxt < CNT_W'(T_LEN)) begin
            for (int j = 0; j < T_LEN; j++) begin
              if (CNT_W'(j) == w_err_num_nxt) w_err_pos_nxt[j] = gf_pos(w_acc_k[i]);
            end
            w_err_num_nxt = w_err_num_nxt + 1'b1;
          end else begin
            w_ovf_nxt = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b1;
    err_pos_vld = 1'b0;
    decode_fail = r_fail_hold;
    case (r_state)
      ST_IDLE: begin
        busy = 1'b0;
        if (sigma_vld) w_state_nxt = ST_SEARCH;
      end
      ST_SEARCH: begin
`ifdef RS_CHIEN_EVAL_PIPE_EN
        if (w_last_beat) w_state_nxt = ST_DRAIN;
`else
        if (w_last_beat) w_state_nxt = ST_DONE;
`endif
      end
`ifdef RS_CHIEN_EVAL_PIPE_EN
      ST_DRAIN: w_state_nxt = ST_DONE;
`endif
      ST_DONE: begin
        err_pos_vld = 1'b1;
        decode_fail = w_fail;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_sigma     <= '0;
      r_sigma_deg <= '0;
      r_beat_cnt  <= '0;
      r_overflow  <= 1'b0;
      r_err_pos   <= '0;
      r_err_num   <= '0;
      r_fail_hold <= 1'b0;
    end else if (w_start) begin
      r_sigma     <= sigma;
      r_sigma_deg <= sigma_deg;
      r_beat_cnt  <= '0;
      r_overflow  <= 1'b0;
      r_err_pos   <= '0;
      r_err_num   <= '0;
      r_fail_hold <= 1'b0;
    end else begin
      r_err_pos  <= w_err_pos_nxt;
      r_err_num  <= w_err_num_nxt;
      r_overflow <= w_ovf_nxt;
      if (w_beat_acc)          r_beat_cnt  <= r_beat_cnt + 1'b1;
      if (r_state == ST_DONE)  r_fail_hold <= w_fail;
    end
  end

  assign err_pos = r_err_pos;
  assign err_num = r_err_num;

endmodule
`default_nettype wire

// File: tb/tb_rs_chien_eval.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rs_chien_eval
//  Purpose  : Self-checking bench for rs_chien_eval (directed table + random).
//  Revision : 1.0  initial release
// ============================================================================
module tb_rs_chien_eval;
  import gf_pkg::*;

  localparam int LANES = ROOTS_PER_CYCLE__CHIEN;
`ifdef RS_CHIEN_EVAL_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  typedef logic [T_LEN:0][SYMB_WIDTH-1:0] sigma_t;
  typedef logic [T_LEN-1:0][SYMB_WIDTH-1:0] pos_t;

  typedef struct {
    string            name;
    sigma_t           s;
    logic [CNT_W-1:0] d;
    int               gap;
    pos_t             e_pos;
    logic [CNT_W-1:0] e_num;
    logic             e_fail;
  } vec_t;

  logic                             aclk = 1'b0;
  logic                             aresetn = 1'b0;
  logic                             sigma_vld = 1'b0;
  sigma_t                           sigma = '0;
  logic [CNT_W-1:0]                 sigma_deg = '0;
  logic                             roots_vld = 1'b0;
  logic [LANES-1:0][SYMB_WIDTH-1:0] roots = '0;
  logic [LANES-1:0][SYMB_WIDTH-1:0] alpha_current = '0;
  logic                             busy;
  logic                             err_pos_vld;
  pos_t                             err_pos;
  logic [CNT_W-1:0]                 err_num;
  logic                             decode_fail;

  int checks = 0;
  int errors = 0;
  int exp_tbl[GF_ORDER];
  int log_tbl[GF_ORDER+1];

  rs_chien_eval dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .sigma_vld     (sigma_vld),
    .sigma         (sigma),
    .sigma_deg     (sigma_deg),
    .roots_vld     (roots_vld),
    .roots         (roots),
    .alpha_current (alpha_current),
    .busy          (busy),
    .err_pos_vld   (err_pos_vld),
    .err_pos       (err_pos),
    .err_num       (err_num),
    .decode_fail   (decode_fail)
  );

  always #5 aclk = ~aclk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int gmul(input int a, input int b);
    if (a == 0 || b == 0) return 0;
    return exp_tbl[(log_tbl[a] + log_tbl[b]) % GF_ORDER];
  endfunction

  // Reference: sum of c_j * alpha^(j*k) for every k, positions in increasing k
  function automatic void model(input sigma_t s, input logic [CNT_W-1:0] d,
                                output pos_t pos, output logic [CNT_W-1:0] num,
                                output logic fail);
    int  n;
    bit  ovf;
    n   = 0;
    ovf = 0;
    pos = '0;
    for (int k = 0; k < GF_ORDER; k++) begin
      int v;
      v = 0;
      for (int j = 0; j <= T_LEN; j++) v = v ^ gmul(int'(s[j]), exp_tbl[(j * k) % GF_ORDER]);
      if (v == 0) begin
        if (n < T_LEN) begin
          pos[n] = SYMB_WIDTH'((GF_ORDER - k) % GF_ORDER);
          n++;
        end else begin
          ovf = 1;
        end
      end
    end
    num  = CNT_W'(n);
    fail = ovf || (n != int'(d));
  endfunction

  function automatic sigma_t rand_sigma();
    sigma_t s;
    for (int j = 0; j <= T_LEN; j++) s[j] = SYMB_WIDTH'($urandom);
    return s;
  endfunction

  task automatic drive_beat(input int b);
    roots_vld = 1'b1;
    for (int i = 0; i < LANES; i++) begin
      int k;
      k = b * LANES + i;
      roots[i]         = SYMB_WIDTH'(exp_tbl[k % GF_ORDER]);
      alpha_current[i] = SYMB_WIDTH'(k);
    end
  endtask

  // gap: 0 none, 1 three idle cycles every five beats (+ stray sigma_vld), 2 random
  task automatic run_search(input sigma_t s, input logic [CNT_W-1:0] d, input int gap,
                            output pos_t g_pos, output logic [CNT_W-1:0] g_num,
                            output logic g_fail, output int g_lat, output int bad);
    bad       = 0;
    sigma_vld = 1'b1;
    sigma     = s;
    sigma_deg = d;
    @(posedge aclk); #1;
    sigma_vld = 1'b0;
    sigma     = rand_sigma();
    sigma_deg = CNT_W'($urandom);
    if (!busy) bad++;
    for (int b = 0; b < CYCLES_NUM__CHIEN; b++) begin
      int ng;
      ng = 0;
      if (gap == 1 && b > 0 && b % 5 == 0) ng = 3;
      else if (gap == 2 && $urandom_range(0, 3) == 0) ng = $urandom_range(1, 3);
      for (int g = 0; g < ng; g++) begin
        roots_vld     = 1'b0;
        roots         = {LANES{SYMB_WIDTH'($urandom)}};
        alpha_current = '0;
        if (gap == 1 && b == 10 && g == 1) sigma_vld = 1'b1;
        @(posedge aclk); #1;
        sigma_vld = 1'b0;
        if (!busy || err_pos_vld) bad++;
      end
      drive_beat(b);
      @(posedge aclk); #1;
      roots_vld = 1'b0;
      if (b < CYCLES_NUM__CHIEN - 1 && (!busy || err_pos_vld)) bad++;
    end
    g_lat = 1;
    while (!err_pos_vld && g_lat < 10) begin
      @(posedge aclk); #1;
      g_lat++;
    end
    if (!err_pos_vld) g_lat = -1;
    g_pos  = err_pos;
    g_num  = err_num;
    g_fail = decode_fail;
  endtask

  task automatic run_and_check(input string name, input sigma_t s, input logic [CNT_W-1:0] d,
                               input int gap, input pos_t e_pos,
                               input logic [CNT_W-1:0] e_num, input logic e_fail);
    pos_t             g_pos;
    logic [CNT_W-1:0] g_num;
    logic             g_fail;
    int               g_lat;
    int               bad;
    run_search(s, d, gap, g_pos, g_num, g_fail, g_lat, bad);
    chk({name, " latency"}, 128'(g_lat), 128'(LAT));
    chk({name, " err_num"}, 128'(g_num), 128'(e_num));
    chk({name, " decode_fail"}, 128'(g_fail), 128'(e_fail));
    chk({name, " err_pos"}, 128'(g_pos), 128'(e_pos));
    chk({name, " busy/vld during search"}, 128'(bad), 128'(0));
    @(posedge aclk); #1;
    chk({name, " vld one cycle"}, 128'(err_pos_vld), 128'(0));
    chk({name, " idle after done"}, 128'(busy), 128'(0));
    chk({name, " hold"}, {err_pos, err_num, decode_fail}, {e_pos, e_num, e_fail});
  endtask

  vec_t vecs[5];

  initial begin
    int v;
    v = 1;
    for (int i = 0; i < GF_ORDER; i++) begin
      exp_tbl[i] = v;
      log_tbl[v] = i;
      v = v << 1;
      if (v > GF_ORDER) v = v ^ 'h11D;
    end
    log_tbl[0] = 0;

    for (int n = 0; n < 5; n++) begin
      vecs[n].s     = '0;
      vecs[n].s[0]  = 8'h01;
      vecs[n].gap   = 0;
      vecs[n].e_pos = '0;
    end
    vecs[0].name = "t1 sigma=1";
    vecs[0].d = 0; vecs[0].e_num = 0; vecs[0].e_fail = 0;

    vecs[1].name = "t2 single root";
    vecs[1].s[1] = 8'h08;
    vecs[1].d = 1; vecs[1].e_num = 1; vecs[1].e_fail = 0; vecs[1].e_pos[0] = 8'd3;

    vecs[2].name = "t3 two roots beat0";
    vecs[2].s[1] = 8'h8F; vecs[2].s[2] = 8'h8E;
    vecs[2].d = 2; vecs[2].e_num = 2; vecs[2].e_fail = 0;
    vecs[2].e_pos[0] = 8'd0; vecs[2].e_pos[1] = 8'd254;

    vecs[3].name = "t4 degree mismatch";
    vecs[3].s[1] = 8'h08;
    vecs[3].d = 2; vecs[3].e_num = 1; vecs[3].e_fail = 1; vecs[3].e_pos[0] = 8'd3;

    vecs[4]      = vecs[2];
    vecs[4].name = "t5 gaps";
    vecs[4].gap  = 1;

    // reset state
    repeat (2) @(posedge aclk);
    #1;
    chk("reset outputs", {busy, err_pos_vld, err_pos, err_num, decode_fail}, '0);
    aresetn = 1'b1;
    @(posedge aclk); #1;

    for (int n = 0; n < 5; n++)
      run_and_check(vecs[n].name, vecs[n].s, vecs[n].d, vecs[n].gap,
                    vecs[n].e_pos, vecs[n].e_num, vecs[n].e_fail);

    // t6: reset during beat 20 of a run that already has hits
    begin
      int seen;
      sigma_vld = 1'b1; sigma = vecs[2].s; sigma_deg = 2;
      @(posedge aclk); #1;
      sigma_vld = 1'b0;
      for (int b = 0; b <= 20; b++) begin
        drive_beat(b);
        if (b == 20) aresetn = 1'b0;
        @(posedge aclk); #1;
      end
      aresetn   = 1'b1;
      roots_vld = 1'b0;
      chk("t6 reset mid-search", {busy, err_pos_vld, err_pos, err_num, decode_fail}, '0);
      seen = 0;
      for (int c = 0; c < 70; c++) begin
        drive_beat(c % CYCLES_NUM__CHIEN);
        @(posedge aclk); #1;
        if (err_pos_vld || busy) seen++;
      end
      roots_vld = 1'b0;
      chk("t6 idle ignores roots", 128'(seen), 128'(0));
      run_and_check("t6 rerun t2", vecs[1].s, vecs[1].d, 0,
                    vecs[1].e_pos, vecs[1].e_num, vecs[1].e_fail);
    end

    // randomized runs against the reference model
    for (int r = 0; r < 12; r++) begin
      sigma_t           s;
      logic [CNT_W-1:0] d;
      pos_t             e_pos;
      logic [CNT_W-1:0] e_num;
      logic             e_fail;
      int               nr;
      bit               used[GF_ORDER];
      s    = '0;
      s[0] = 8'h01;
      nr   = $urandom_range(0, T_LEN);
      if (r % 2 == 0) begin
        for (int k = 0; k < GF_ORDER; k++) used[k] = 0;
        for (int q = 0; q < nr; q++) begin
          int k;
          int c;
          k = $urandom_range(0, GF_ORDER - 1);
          while (used[k]) k = (k + 1) % GF_ORDER;
          used[k] = 1;
          c = exp_tbl[(GF_ORDER - k) % GF_ORDER];
          for (int j = T_LEN; j >= 1; j--)
            s[j] = s[j] ^ SYMB_WIDTH'(gmul(c, int'(s[j-1])));
        end
      end else begin
        for (int j = 1; j <= nr; j++) s[j] = SYMB_WIDTH'($urandom);
      end
      d = CNT_W'(nr);
      if ($urandom_range(0, 3) == 0) d = CNT_W'((nr + 1) % (T_LEN + 1));
      model(s, d, e_pos, e_num, e_fail);
      run_and_check($sformatf("rand%0d", r), s, d, (r % 3 == 0) ? 2 : 0, e_pos, e_num, e_fail);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
